// File: rtl/vga_frame_reader.sv
// vga_frame_reader
//   Raster scan-out of the one-bit stopwatch frame buffer to a VGA monitor.
//   Generates the horizontal/vertical counters, drives a synchronous-read
//   address port into the frame buffer and produces registered hsync, vsync
//   and 12-bit RGB. It also flags vertical blanking and the frame wrap so the
//   digit drawer can confine its buffer updates to blanking.
//
// Ports
//   clk          rising-edge system clock
//   reset_n      asynchronous active-low reset
//   pix_en       pixel tick; all state advances only on clocks with pix_en=1
//   fb_rd_en     frame buffer read strobe (combinational)
//   fb_addr      frame buffer read address, y*H_ACTIVE+x
//   fb_data      read data (1=ON), valid from the clk after fb_rd_en
//   hsync/vsync  active-low syncs (registered)
//   rgb          {R,G,B} 4 bits each (registered)
//   video_on     rgb belongs to the visible area (registered)
//   vblank       scan position is in vertical blanking (registered)
//   frame_start  one-clk pulse after the counters wrap to (0,0)
module vga_frame_reader #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FRONT    = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BACK     = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FRONT    = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BACK     = 33,
  parameter int          ADDR_WIDTH = 19,
  parameter logic [11:0] FG_COLOR   = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pix_en,
  output logic                  fb_rd_en,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  input  logic                  fb_data,
  output logic                  hsync,
  output logic                  vsync,
  output logic [11:0]           rgb,
  output logic                  video_on,
  output logic                  vblank,
  output logic                  frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST  = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_LAST   = HW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST  = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_LAST   = VW'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic [HW-1:0]         h_cnt_q, h_cnt_d;
  logic [VW-1:0]         v_cnt_q, v_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  hs1_q, hs1_d;
  logic                  vs1_q, vs1_d;
  logic                  act1_q, act1_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic [11:0]           rgb_q, rgb_d;
  logic                  video_on_q, video_on_d;
  logic                  vblank_q, vblank_d;
  logic                  frame_start_q, frame_start_d;

  logic active;
  logic h_last;
  logic v_last;
  logic hs_raw;
  logic vs_raw;

  always_comb begin
    active = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    h_last = (h_cnt_q == H_LAST);
    v_last = (v_cnt_q == V_LAST);
    hs_raw = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    vs_raw = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
  end

  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    addr_d        = addr_q;
    hs1_d         = hs1_q;
    vs1_d         = vs1_q;
    act1_d        = act1_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    rgb_d         = rgb_q;
    video_on_d    = video_on_q;
    vblank_d      = vblank_q;
    frame_start_d = 1'b0;

    if (pix_en) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end

      // Row-major address advances only over visible pixels, so at every
      // visible (x,y) it already equals y*H_ACTIVE+x without a multiplier.
      if (h_last && v_last) begin
        addr_d = '0;
      end else if (active) begin
        addr_d = addr_q + ADDR_WIDTH'(1);
      end

      // Stage 1 lines sync/active up with the frame buffer read latency.
      hs1_d  = hs_raw;
      vs1_d  = vs_raw;
      act1_d = active;

      hsync_d    = hs1_q;
      vsync_d    = vs1_q;
      video_on_d = act1_q;
      // Blanking is forced black even when the background colour is not.
      rgb_d      = act1_q ? (fb_data ? FG_COLOR : BG_COLOR) : 12'h000;
      vblank_d   = (v_cnt_q >= V_ACT_END);

      frame_start_d = h_last && v_last;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      addr_q        <= '0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      act1_q        <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= 12'h000;
      video_on_q    <= 1'b0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      addr_q        <= addr_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      act1_q        <= act1_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      video_on_q    <= video_on_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Gated by reset_n so no read is issued while the block is held in reset.
  assign fb_rd_en    = pix_en && active && reset_n;
  assign fb_addr     = addr_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb         = rgb_q;
  assign video_on    = video_on_q;
  assign vblank      = vblank_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
module tb_vga_frame_reader;

  // Reduced geometry for the scoreboard instance so whole frames fit in a short run.
  localparam int S_HA = 7;
  localparam int S_HF = 2;
  localparam int S_HS = 3;
  localparam int S_HB = 2;
  localparam int S_VA = 6;
  localparam int S_VF = 1;
  localparam int S_VS = 2;
  localparam int S_VB = 2;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam int S_FRAME = S_HT * S_VT;
  localparam logic [11:0] S_FG = 12'hABC;
  localparam logic [11:0] S_BG = 12'h123;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  // full-size instance (default geometry)
  logic        pix_en_f = 1'b0;
  logic        fb_rd_en_f;
  logic [18:0] fb_addr_f;
  logic        fb_data_f = 1'b0;
  logic        hsync_f, vsync_f, video_on_f, vblank_f, frame_start_f;
  logic [11:0] rgb_f;

  // reduced instance
  logic        pix_en_s = 1'b0;
  logic        fb_rd_en_s;
  logic [18:0] fb_addr_s;
  logic        fb_data_s = 1'b0;
  logic        hsync_s, vsync_s, video_on_s, vblank_s, frame_start_s;
  logic [11:0] rgb_s;

  vga_frame_reader dut_full (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en_f),
    .fb_rd_en(fb_rd_en_f), .fb_addr(fb_addr_f), .fb_data(fb_data_f),
    .hsync(hsync_f), .vsync(vsync_f), .rgb(rgb_f),
    .video_on(video_on_f), .vblank(vblank_f), .frame_start(frame_start_f)
  );

  vga_frame_reader #(
    .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .ADDR_WIDTH(19), .FG_COLOR(S_FG), .BG_COLOR(S_BG)
  ) dut_small (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en_s),
    .fb_rd_en(fb_rd_en_s), .fb_addr(fb_addr_s), .fb_data(fb_data_s),
    .hsync(hsync_s), .vsync(vsync_s), .rgb(rgb_s),
    .video_on(video_on_s), .vblank(vblank_s), .frame_start(frame_start_s)
  );

  // Checkerboard frame buffers: data = addr[0], one clk read latency.
  always @(posedge clk) if (fb_rd_en_f) fb_data_f <= fb_addr_f[0];
  always @(posedge clk) if (fb_rd_en_s) fb_data_s <= fb_addr_s[0];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- full-size table ----------------
  typedef struct {
    int          s;
    logic        rd;
    logic        addr_chk;
    int          addr;
    logic        hs;
    logic        vid;
    logic [11:0] rgb;
  } fvec_t;

  fvec_t ftab[18];

  // ---------------- reduced-instance scoreboard ----------------
  typedef struct {
    logic        hs;
    logic        vs;
    logic        vid;
    logic [11:0] rgb;
  } orec_t;

  orec_t sb[$];
  orec_t last_exp;
  logic  exp_vb;
  logic  exp_fs;
  int    mh;
  int    mv;

  function automatic logic m_active(input int h, input int v);
    return (h < S_HA) && (v < S_VA);
  endfunction

  function automatic orec_t model_rec(input int h, input int v);
    orec_t r;
    r.vid = m_active(h, v);
    r.hs  = !((h >= S_HA + S_HF) && (h < S_HA + S_HF + S_HS));
    r.vs  = !((v >= S_VA + S_VF) && (v < S_VA + S_VF + S_VS));
    if (!r.vid) r.rgb = 12'h000;
    else r.rgb = (((v * S_HA + h) % 2) == 1) ? S_FG : S_BG;
    return r;
  endfunction

  task automatic s_reset_model();
    orec_t r;
    r = '{hs: 1'b1, vs: 1'b1, vid: 1'b0, rgb: 12'h000};
    mh = 0;
    mv = 0;
    sb.delete();
    sb.push_back(r);
    last_exp = r;
    exp_vb = 1'b0;
    exp_fs = 1'b0;
  endtask

  task automatic s_cycle(input logic pe);
    logic act;
    @(negedge clk);
    pix_en_s = pe;
    #1;
    act = m_active(mh, mv);
    chk("s_rd_en", 32'(fb_rd_en_s), 32'(pe && act));
    if (pe && act) chk("s_addr", 32'(fb_addr_s), 32'(mv * S_HA + mh));
    if (pe) begin
      sb.push_back(model_rec(mh, mv));
      exp_vb = (mv >= S_VA);
      exp_fs = (mh == S_HT - 1) && (mv == S_VT - 1);
      if (mh == S_HT - 1) begin
        mh = 0;
        mv = (mv == S_VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end else begin
      exp_fs = 1'b0;
    end
    @(posedge clk);
    #1;
    if (pe && sb.size() >= 2) last_exp = sb.pop_front();
    chk("s_hsync", 32'(hsync_s), 32'(last_exp.hs));
    chk("s_vsync", 32'(vsync_s), 32'(last_exp.vs));
    chk("s_video_on", 32'(video_on_s), 32'(last_exp.vid));
    chk("s_rgb", 32'(rgb_s), 32'(last_exp.rgb));
    chk("s_vblank", 32'(vblank_s), 32'(exp_vb));
    chk("s_frame_start", 32'(frame_start_s), 32'(exp_fs));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hsync"}, 32'(hsync_s), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync_s), 32'd1);
    chk({tag, "_rgb"}, 32'(rgb_s), 32'd0);
    chk({tag, "_video_on"}, 32'(video_on_s), 32'd0);
    chk({tag, "_vblank"}, 32'(vblank_s), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start_s), 32'd0);
    chk({tag, "_rd_en"}, 32'(fb_rd_en_s), 32'd0);
    chk({tag, "_addr"}, 32'(fb_addr_s), 32'd0);
    chk({tag, "_f_rd_en"}, 32'(fb_rd_en_f), 32'd0);
    chk({tag, "_f_hsync"}, 32'(hsync_f), 32'd1);
    chk({tag, "_f_rgb"}, 32'(rgb_f), 32'd0);
  endtask

  initial begin
    int s;
    int guard;

    // Sample index s is taken just before the s-th pix_en edge after release:
    // comb outputs show position s, registered outputs show position s-2.
    ftab[0]  = '{0,    1'b1, 1'b1, 0,    1'b1, 1'b0, 12'h000};
    ftab[1]  = '{1,    1'b1, 1'b1, 1,    1'b1, 1'b0, 12'h000};
    ftab[2]  = '{2,    1'b1, 1'b1, 2,    1'b1, 1'b1, 12'h000};
    ftab[3]  = '{3,    1'b1, 1'b1, 3,    1'b1, 1'b1, 12'hFFF};
    ftab[4]  = '{639,  1'b1, 1'b1, 639,  1'b1, 1'b1, 12'hFFF};
    ftab[5]  = '{640,  1'b0, 1'b0, 0,    1'b1, 1'b1, 12'h000};
    ftab[6]  = '{641,  1'b0, 1'b0, 0,    1'b1, 1'b1, 12'hFFF};
    ftab[7]  = '{642,  1'b0, 1'b0, 0,    1'b1, 1'b0, 12'h000};
    ftab[8]  = '{657,  1'b0, 1'b0, 0,    1'b1, 1'b0, 12'h000};
    ftab[9]  = '{658,  1'b0, 1'b0, 0,    1'b0, 1'b0, 12'h000};
    ftab[10] = '{753,  1'b0, 1'b0, 0,    1'b0, 1'b0, 12'h000};
    ftab[11] = '{754,  1'b0, 1'b0, 0,    1'b1, 1'b0, 12'h000};
    ftab[12] = '{800,  1'b1, 1'b1, 640,  1'b1, 1'b0, 12'h000};
    ftab[13] = '{801,  1'b1, 1'b1, 641,  1'b1, 1'b0, 12'h000};
    ftab[14] = '{802,  1'b1, 1'b1, 642,  1'b1, 1'b1, 12'h000};
    ftab[15] = '{803,  1'b1, 1'b1, 643,  1'b1, 1'b1, 12'hFFF};
    ftab[16] = '{1439, 1'b1, 1'b1, 1279, 1'b1, 1'b1, 12'hFFF};
    ftab[17] = '{1458, 1'b0, 1'b0, 0,    1'b0, 1'b0, 12'h000};

    // Reset hold with pix_en toggling.
    #1 reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pix_en_f = i[0];
      pix_en_s = i[0];
      #1;
      chk_reset_vals("rst_hold");
    end
    @(negedge clk);
    pix_en_f = 1'b0;
    pix_en_s = 1'b0;
    reset_n  = 1'b1;

    // Full-size line timing from the table.
    s = -1;
    for (int i = 0; i < 18; i++) begin
      while (s < ftab[i].s) begin
        @(negedge clk);
        pix_en_f = 1'b1;
        #1;
        s++;
      end
      chk($sformatf("f_rd_en@%0d", ftab[i].s), 32'(fb_rd_en_f), 32'(ftab[i].rd));
      if (ftab[i].addr_chk)
        chk($sformatf("f_addr@%0d", ftab[i].s), 32'(fb_addr_f), 32'(ftab[i].addr));
      chk($sformatf("f_hsync@%0d", ftab[i].s), 32'(hsync_f), 32'(ftab[i].hs));
      chk($sformatf("f_video_on@%0d", ftab[i].s), 32'(video_on_f), 32'(ftab[i].vid));
      chk($sformatf("f_rgb@%0d", ftab[i].s), 32'(rgb_f), 32'(ftab[i].rgb));
    end
    @(negedge clk);
    pix_en_f = 1'b0;

    // Reduced instance, still at reset state: two frames with pix_en every clk.
    s_reset_model();
    for (int i = 0; i < 2 * S_FRAME + 20; i++) s_cycle(1'b1);

    // pix_en every second clk: every output held for 2 clk.
    for (int i = 0; i < S_FRAME + 10; i++) begin
      s_cycle(1'b1);
      s_cycle(1'b0);
    end

    // Irregular gaps.
    for (int i = 0; i < 120; i++) s_cycle(1'($urandom_range(0, 1)));

    // Mid-frame reset inside the visible area.
    guard = 0;
    while (!(mh == 4 && mv == 3) && guard < 2 * S_FRAME) begin
      s_cycle(1'b1);
      guard++;
    end
    @(negedge clk);
    pix_en_s = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk_reset_vals("mid_rst_hold");
    end
    @(negedge clk);
    pix_en_s = 1'b0;
    reset_n  = 1'b1;
    s_reset_model();
    for (int i = 0; i < S_FRAME + 20; i++) s_cycle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Scans the 640x480 one-bit stopwatch frame buffer out to a VGA monitor. It is the read side of the image path: the digit drawer writes ON/OFF pixels into the frame buffer, and this block reads them back in raster order. It generates the 640x480@60 Hz horizontal and vertical counters, drives a synchronous-read address port into the frame buffer, and outputs hsync, vsync and 12-bit RGB. It also flags vertical blanking and frame start so the drawer can restrict its updates to blanking.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- ADDR_WIDTH, 19, frame buffer address width
- FG_COLOR, 12'hFFF, colour of an ON pixel
- BG_COLOR, 12'h000, colour of an OFF pixel inside the active area

Ports:
- clk  in  1  system clock; all flops are on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel tick; the block advances exactly one pixel per clk with pix_en=1
- fb_rd_en  out  1  frame buffer read strobe (combinational)
- fb_addr  out  ADDR_WIDTH  frame buffer read address, row-major: y*H_ACTIVE+x
- fb_data  in  1  read data, 1=ON; valid from the clk after fb_rd_en until the next read
- hsync  out  1  active-low horizontal sync (registered)
- vsync  out  1  active-low vertical sync (registered)
- rgb  out  12  {R[3:0],G[3:0],B[3:0]} (registered)
- video_on  out  1  rgb is in the active area (registered)
- vblank  out  1  high while v_cnt >= V_ACTIVE (registered)
- frame_start  out  1  one-clk pulse on frame wrap

## Operation
- h_cnt wraps at H_TOTAL-1 = 799. v_cnt increments when h_cnt wraps, and wraps at V_TOTAL-1 = 524. Both counters change only on pix_en.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- fb_rd_en = pix_en && active && reset_n.
- fb_addr is an incremental pointer, with no multiplier:
  - it increments by 1 on each pix_en tick where active=1;
  - it is cleared to 0 on frame wrap (799,524)->(0,0);
  - it equals y*640+x, and the last pixel of a frame reads address 307199.
- Stage 1, updated on pix_en:
  - the delayed values of hs_raw, vs_raw and active are registered;
  - hs_raw = 0 for h_cnt in [656,751], otherwise 1;
  - vs_raw = 0 for v_cnt in [490,491], otherwise 1.
- Outputs, updated on pix_en:
  - hsync and vsync take the stage-1 values;
  - video_on takes stage-1 active;
  - rgb = stage-1 active ? (fb_data ? FG_COLOR : BG_COLOR) : 12'h000. Blanking is always black, regardless of BG_COLOR.
- vblank = registered (v_cnt >= V_ACTIVE).
- frame_start is high for exactly one clk: the clk following the pix_en tick on which the counters wrap to (0,0).
- The drawer may write the buffer freely while vblank=1. Writes while vblank=0 can tear; this block does not guard against that.

## Timing
- Reset values (asynchronous, while reset_n=0):
  - h_cnt=0, v_cnt=0, fb_addr=0;
  - fb_rd_en=0, hsync=1, vsync=1, rgb=0;
  - video_on=0, vblank=0, frame_start=0;
  - stage-1 registers inactive (sync=1, active=0).
- Latency: the output registers reflect counter position (h,v) one pix_en tick after that position was presented. With pix_en=1 every cycle, this is 2 clk from address to rgb.
- Gaps in pix_en (e.g. pix_en every 2nd clk from a 50 MHz clock) freeze all state. fb_data must stay stable until the next pix_en.
- Reset deassertion mid-frame restarts scanning at (0,0) on the first pix_en. The first frame_start follows a full 420000-tick frame.
- Frame period is 800*525 = 420000 pix_en ticks. hsync low: 96 ticks per line. vsync low: 2*800 = 1600 ticks per frame.

## Test plan
- Reset check: hold reset_n=0 with pix_en toggling -> all outputs stay at their reset values and fb_rd_en=0. Release reset -> the first fb_rd_en has fb_addr=0.
- Line timing (pix_en=1 every clk): hsync falls 657 ticks after reset release, stays low 96 ticks, and repeats every 800 ticks. video_on is high for 640 ticks per line.
- Frame timing: vsync is low for 1600 consecutive ticks starting at tick 490*800+1. frame_start pulses every 420000 ticks. vblank is high for 45*800 ticks per frame.
- Checkerboard memory model (fb_data = addr[0], 1-clk read latency):
  - rgb alternates 000, FFF starting at pixel (0,0);
  - the last active fb_addr is 307199;
  - rgb=000 during blanking.
- pix_en every 2nd clk: identical output sequence with every output value held for 2 clk. The frame period is 840000 clk.
- Mid-frame reset at (300,200): outputs return to reset values immediately (asynchronously). After release, scanning resumes at (0,0) with fb_addr=0.
